// File: rtl/brc_pkg.sv
// Shared constants and types for the RV32I branch comparator.
package brc_pkg;

    // Default operand width for the RV32I datapath.
    localparam int unsigned BRC_WIDTH = 32;

    // Values of br_un selecting the comparison mode.
    localparam logic BR_UNSIGNED = 1'b1;
    localparam logic BR_SIGNED   = 1'b0;

    // Operand type at the default width.
    typedef logic [BRC_WIDTH-1:0] brc_operand_t;

endpackage : brc_pkg

// File: rtl/brc_cmp4.sv
// 4-bit unsigned slice comparator: leaf of the magnitude-compare tree.
module brc_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       eq
);

    // Local 4-bit compare; narrow enough that no wide carry chain results.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
    end

endmodule : brc_cmp4

// File: rtl/brc_unit.sv
// Branch comparator: combinational less/equal flags plus registered copies.
// WIDTH must be a multiple of 4 and at least 8.
module brc_unit
    import brc_pkg::*;
#(
    parameter int unsigned WIDTH = BRC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             br_un,
    output logic             br_less,
    output logic             br_equal,
    output logic             br_less_q,
    output logic             br_equal_q
);

    localparam int unsigned NumSlices = WIDTH / 4;
    // Tree is padded up to a power of two; heap layout, node 0 is the root.
    localparam int unsigned NumLevels = (NumSlices > 1) ? $clog2(NumSlices) : 1;
    localparam int unsigned NumLeaves = 1 << NumLevels;
    localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

    logic [NumSlices-1:0] slice_lt;
    logic [NumSlices-1:0] slice_eq;
    logic [NumNodes-1:0]  node_lt;
    logic [NumNodes-1:0]  node_eq;
    logic                 mag_lt;
    logic                 mag_eq;
    logic                 sign_diff;

    for (genvar s = 0; s < NumSlices; s++) begin : g_slice
        brc_cmp4 u_cmp4 (
            .a  (rs1_data[4*s +: 4]),
            .b  (rs2_data[4*s +: 4]),
            .lt (slice_lt[s]),
            .eq (slice_eq[s])
        );
    end

    // Reduce slice results MSB-first. Left child is the more significant half.
    // Padding leaves use (lt=0, eq=1), the identity of the combine operator.
    always_comb begin
        node_lt = '0;
        node_eq = '0;
        for (int j = 0; j < int'(NumLeaves); j++) begin
            if (j >= int'(NumLeaves - NumSlices)) begin
                node_lt[int'(NumLeaves) - 1 + j] = slice_lt[int'(NumLeaves) - 1 - j];
                node_eq[int'(NumLeaves) - 1 + j] = slice_eq[int'(NumLeaves) - 1 - j];
            end else begin
                node_lt[int'(NumLeaves) - 1 + j] = 1'b0;
                node_eq[int'(NumLeaves) - 1 + j] = 1'b1;
            end
        end
        for (int n = int'(NumLeaves) - 2; n >= 0; n--) begin
            node_lt[n] = node_lt[2*n+1] | (node_eq[2*n+1] & node_lt[2*n+2]);
            node_eq[n] = node_eq[2*n+1] & node_eq[2*n+2];
        end
        mag_lt = node_lt[0];
        mag_eq = node_eq[0];
    end

    // Signed fix-up: differing sign bits decide the result on their own.
    always_comb begin
        sign_diff = rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1];
        if ((br_un == BR_SIGNED) && sign_diff) begin
            br_less = rs1_data[WIDTH-1];
        end else begin
            br_less = mag_lt;
        end
        br_equal = mag_eq;
    end

    // Registered flag copies for pipeline/debug consumers.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_less_q  <= 1'b0;
            br_equal_q <= 1'b0;
        end else begin
            br_less_q  <= br_less;
            br_equal_q <= br_equal;
        end
    end

endmodule : brc_unit

// File: tb/tb_brc_unit.sv
// Directed and randomized checks for brc_unit.
module tb_brc_unit;
    import brc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    brc_operand_t rs1_data;
    brc_operand_t rs2_data;
    logic         br_un;
    logic         br_less;
    logic         br_equal;
    logic         br_less_q;
    logic         br_equal_q;

    int total = 0;
    int bad   = 0;

    brc_unit #(
        .WIDTH (BRC_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .br_un      (br_un),
        .br_less    (br_less),
        .br_equal   (br_equal),
        .br_less_q  (br_less_q),
        .br_equal_q (br_equal_q)
    );

    always #5 clk = ~clk;

    // Stimulus only: drive operands and let the combinational flags settle.
    task automatic apply(input brc_operand_t a, input brc_operand_t b, input logic un);
        rs1_data = a;
        rs2_data = b;
        br_un    = un;
        #1;
    endtask

    // Hold reset with equal operands, release, then pulse reset mid-stream.
    task automatic test_reset();
        rst = 1'b1;
        apply(32'h0000_0010, 32'h0000_0010, BR_UNSIGNED);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (br_equal_q !== 1'b0 || br_less_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_q: less_q=%b equal_q=%b, want 0 0", br_less_q, br_equal_q);
        end
        total++;
        if (br_equal !== 1'b1 || br_less !== 1'b0) begin
            bad++;
            $display("FAIL reset_comb: less=%b equal=%b, want 0 1", br_less, br_equal);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (br_equal_q !== 1'b1 || br_less_q !== 1'b0) begin
            bad++;
            $display("FAIL release_q: less_q=%b equal_q=%b, want 0 1", br_less_q, br_equal_q);
        end
        // Switch to a less-than pair; latency is one edge.
        apply(32'h0000_0010, 32'h0000_0020, BR_UNSIGNED);
        total++;
        if (br_less_q !== 1'b0 || br_equal_q !== 1'b1) begin
            bad++;
            $display("FAIL latency_hold: less_q=%b equal_q=%b, want 0 1", br_less_q, br_equal_q);
        end
        @(posedge clk);
        #1;
        total++;
        if (br_less_q !== 1'b1 || br_equal_q !== 1'b0) begin
            bad++;
            $display("FAIL latency_load: less_q=%b equal_q=%b, want 1 0", br_less_q, br_equal_q);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (br_less_q !== 1'b0 || br_equal_q !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: less_q=%b equal_q=%b, want 0 0", br_less_q, br_equal_q);
        end
        total++;
        if (br_less !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_comb: less=%b, want 1", br_less);
        end
        @(posedge clk);
        #1;
        total++;
        if (br_less_q !== 1'b1 || br_equal_q !== 1'b0) begin
            bad++;
            $display("FAIL resume: less_q=%b equal_q=%b, want 1 0", br_less_q, br_equal_q);
        end
    endtask

    // Equal operands in both modes, including all-zeros.
    task automatic test_equal();
        brc_operand_t va [4] = '{32'h10, 32'h10, 32'h0, 32'h0};
        logic         vu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply(va[i], va[i], vu[i]);
            total++;
            if (br_equal !== 1'b1 || br_less !== 1'b0) begin
                bad++;
                $display("FAIL equal[%0d]: less=%b equal=%b, want 0 1", i, br_less, br_equal);
            end
        end
    endtask

    // rs1 > rs2 with matching signs: neither flag in either mode.
    task automatic test_greater();
        for (int m = 0; m < 2; m++) begin
            apply(32'h11, 32'h10, logic'(m));
            total++;
            if (br_equal !== 1'b0 || br_less !== 1'b0) begin
                bad++;
                $display("FAIL greater[un=%0d]: less=%b equal=%b, want 0 0", m, br_less,
                         br_equal);
            end
        end
    endtask

    // Operand pairs whose sign bits differ; result flips with the mode.
    task automatic test_sign_cross();
        brc_operand_t va [4] = '{32'h0000_0010, 32'h0000_0010, 32'hFFFF_FFFA, 32'hFFFF_FFFA};
        brc_operand_t vb [4] = '{32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'h0000_0005, 32'h0000_0005};
        logic         vu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic         vl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(va[i], vb[i], vu[i]);
            total++;
            if (br_less !== vl[i] || br_equal !== 1'b0) begin
                bad++;
                $display("FAIL sign_cross[%0d]: less=%b equal=%b, want %b 0", i, br_less,
                         br_equal, vl[i]);
            end
        end
    endtask

    // Both negative, plus the boundary pairs.
    task automatic test_negative();
        brc_operand_t va [7] = '{32'hFFFF_FFF1, 32'hFFFF_FFF1, 32'hFFFF_FFEF, 32'hFFFF_FFEF,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        brc_operand_t vb [7] = '{32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'hFFFF_FFEE, 32'hFFFF_FFEE,
                                 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic         vu [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic         vl [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            apply(va[i], vb[i], vu[i]);
            total++;
            if (br_less !== vl[i] || br_equal !== 1'b0) begin
                bad++;
                $display("FAIL negative[%0d]: less=%b equal=%b, want %b 0", i, br_less,
                         br_equal, vl[i]);
            end
        end
    endtask

    // Corner cross-product plus random vectors against a reference compare.
    task automatic test_random();
        brc_operand_t corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                      32'h7FFF_FFFF};
        brc_operand_t a;
        brc_operand_t b;
        logic         un;
        logic         exp_lt;
        logic         exp_eq;
        for (int n = 0; n < 50 + 10000; n++) begin
            if (n < 50) begin
                a  = corners[n % 5];
                b  = corners[(n / 5) % 5];
                un = logic'(n / 25);
            end else begin
                a  = $urandom();
                b  = ($urandom_range(0, 7) == 0) ? a : brc_operand_t'($urandom());
                un = logic'($urandom_range(0, 1));
                // Occasionally share upper bits so low slices decide the result.
                if ($urandom_range(0, 3) == 0) b[31:12] = a[31:12];
            end
            exp_lt = un ? (a < b) : ($signed(a) < $signed(b));
            exp_eq = (a == b);
            apply(a, b, un);
            total++;
            if (br_less !== exp_lt || br_equal !== exp_eq) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h un=%b: less=%b equal=%b, want %b %b", n,
                         a, b, un, br_less, br_equal, exp_lt, exp_eq);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        rs1_data = '0;
        rs2_data = '0;
        br_un    = BR_UNSIGNED;
        test_reset();
        test_equal();
        test_greater();
        test_sign_cross();
        test_negative();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_brc_unit
